kanagawa_loop_collector: RTL and testbench

// - Inverse of the pipelined-call loop generator: collapses the N per-thread entries of one

---
 rtl/kanagawa_loop_collector.sv | 124 ++++++++++++
 tb/tb_kanagawa_loop_collector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/kanagawa_loop_collector.sv
// kanagawa_loop_collector
//
// Return-side collector for a pipelined function call. A call that was fanned
// out into N threads (thread IDs 0..max) comes back as N entries on the input
// FIFO; this block pops all of them and emits a single entry, the one carried
// by the last thread, into a one-deep registered output slot.
//
// Ports:
//   clk                 clock
//   rst_n               synchronous reset, active low
//   empty_in            input FIFO empty
//   data_in             input FIFO head entry (one thread)
//   rden_out            pop request to the input FIFO
//   data_out            collected entry
//   empty_out           no collected entry available
//   rden_in             consumer pops the collected entry
//   underflow_out       sticky: rden_in seen while empty_out
//   sequence_error_out  sticky: thread ID arrived out of order
//
// Handshake: both sides are FIFO style. An entry transfers on a cycle where
// the reader's rden is high and the writer's empty is low. rden is only
// meaningful while empty is low; the consumer raising rden_in while
// empty_out is high is recorded as an underflow and otherwise ignored.
//
// Optional feature: define KANAGAWA_LOOP_COLLECTOR_SEQ_CHECK_EN to enable
// thread-ID ordering checks. Without it, sequence_error_out is tied low.
module kanagawa_loop_collector #(
  parameter int TOTAL_WIDTH               = 64,
  parameter int COUNTER_WIDTH             = 8,
  parameter int HAS_LITERAL_MAX_THREAD_ID = 0,
  parameter int LITERAL_MAX_THREAD_ID     = 0,
  parameter int OFFSET                    = 0,
  parameter int MAX_OFFSET                = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     empty_in,
  input  logic [TOTAL_WIDTH-1:0]   data_in,
  output logic                     rden_out,
  output logic [TOTAL_WIDTH-1:0]   data_out,
  output logic                     empty_out,
  input  logic                     rden_in,
  output logic                     underflow_out,
  output logic                     sequence_error_out
);

  logic [COUNTER_WIDTH-1:0] tid;
  logic [COUNTER_WIDTH-1:0] max_id;
  logic                     is_last;
  logic                     pop;

  logic                     out_valid;
  logic [TOTAL_WIDTH-1:0]   out_data;
  logic [COUNTER_WIDTH-1:0] expected_id;
  logic                     underflow_q;

  assign tid    = data_in[OFFSET +: COUNTER_WIDTH];
  assign max_id = (HAS_LITERAL_MAX_THREAD_ID != 0)
                  ? COUNTER_WIDTH'(LITERAL_MAX_THREAD_ID)
                  : data_in[MAX_OFFSET +: COUNTER_WIDTH];
  assign is_last = (tid == max_id);

  // Non-last threads always drain. The last thread only waits while the
  // output slot is full and not being emptied this same cycle.
  assign pop      = !empty_in && (!is_last || !out_valid || rden_in);
  assign rden_out = pop;

  assign empty_out     = !out_valid;
  assign data_out      = out_data;
  assign underflow_out = underflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      expected_id <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (rden_in && !out_valid) begin
        underflow_q <= 1'b1;
      end
      // Drain first; a same-cycle last-thread pop overrides and refills the
      // slot so back-to-back single-thread calls run at one per cycle.
      if (rden_in && out_valid) begin
        out_valid <= 1'b0;
      end
      if (pop) begin
        if (is_last) begin
          out_valid   <= 1'b1;
          expected_id <= '0;
        end else begin
          expected_id <= expected_id + 1'b1;
        end
      end
    end
  end

  // Data register needs no reset: it is only observed while out_valid is set.
  always_ff @(posedge clk) begin
    if (pop && is_last) begin
      out_data <= data_in;
    end
  end

`ifdef KANAGAWA_LOOP_COLLECTOR_SEQ_CHECK_EN
  logic seq_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_err_q <= 1'b0;
    end else if (pop && (tid != expected_id)) begin
      seq_err_q <= 1'b1;
    end
  end

  assign sequence_error_out = seq_err_q;
`else
  // expected_id has no reader in this build; fold it into a sink so the
  // register is kept visible for debug without tripping unused-signal lint.
  logic unused_expected_id;
  assign unused_expected_id = ^expected_id;
  assign sequence_error_out = 1'b0;
`endif

endmodule

// File: tb/tb_kanagawa_loop_collector.sv
// Bench for kanagawa_loop_collector: directed vectors with hand-computed
// expectations. Two instances share clk/rst_n: one in dynamic max-ID mode,
// one in literal mode with max thread ID 7.
module tb_kanagawa_loop_collector;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         empty_in, rden_out, empty_out, rden_in;
  logic         underflow_out, sequence_error_out;
  logic [W-1:0] data_in, data_out;

  logic         l_empty_in, l_rden_out, l_empty_out, l_rden_in;
  logic         l_underflow_out, l_sequence_error_out;
  logic [W-1:0] l_data_in, l_data_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kanagawa_loop_collector dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .empty_in           (empty_in),
    .data_in            (data_in),
    .rden_out           (rden_out),
    .data_out           (data_out),
    .empty_out          (empty_out),
    .rden_in            (rden_in),
    .underflow_out      (underflow_out),
    .sequence_error_out (sequence_error_out)
  );

  kanagawa_loop_collector #(
    .HAS_LITERAL_MAX_THREAD_ID (1),
    .LITERAL_MAX_THREAD_ID     (7)
  ) dut_lit (
    .clk                (clk),
    .rst_n              (rst_n),
    .empty_in           (l_empty_in),
    .data_in            (l_data_in),
    .rden_out           (l_rden_out),
    .data_out           (l_data_out),
    .empty_out          (l_empty_out),
    .rden_in            (l_rden_in),
    .underflow_out      (l_underflow_out),
    .sequence_error_out (l_sequence_error_out)
  );

  // Entry layout: [7:0] tid, [15:8] max, [63:16] payload.
  function automatic logic [W-1:0] mk(input int tid, input int mx, input int payload);
    mk = {48'(payload), 8'(mx), 8'(tid)};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven/sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    empty_in   = 1'b1;
    rden_in    = 1'b0;
    data_in    = '0;
    l_empty_in = 1'b1;
    l_rden_in  = 1'b0;
    l_data_in  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [W-1:0] ent_a, ent_b;
  logic         exp_seq;

  initial begin
    do_reset();
    #1;
    check("reset_empty", W'(empty_out), W'(1));
    check("reset_underflow", W'(underflow_out), W'(0));
    check("reset_seqerr", W'(sequence_error_out), W'(0));
    check("reset_lit_empty", W'(l_empty_out), W'(1));

    // max=3, tids 0..3 back to back with rden_in held high.
    rden_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      empty_in = 1'b0;
      data_in  = mk(k, 3, 16'h1230 + k);
      #1;
      check($sformatf("m3_rden_t%0d", k), W'(rden_out), W'(1));
      check($sformatf("m3_empty_t%0d", k), W'(empty_out), W'(1));
      tick();
    end
    empty_in = 1'b1;
    #1;
    check("m3_out_valid", W'(empty_out), W'(0));
    check("m3_out_data", data_out, mk(3, 3, 16'h1233));
    tick();
    check("m3_out_once", W'(empty_out), W'(1));

    // max=0: five calls, one output per cycle, no stall.
    do_reset();
    rden_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      empty_in = 1'b0;
      data_in  = mk(0, 0, 100 + i);
      #1;
      check($sformatf("m0_rden_%0d", i), W'(rden_out), W'(1));
      if (i > 0) begin
        check($sformatf("m0_valid_%0d", i), W'(empty_out), W'(0));
        check($sformatf("m0_data_%0d", i), data_out, mk(0, 0, 100 + i - 1));
      end
      tick();
    end
    empty_in = 1'b1;
    #1;
    check("m0_valid_last", W'(empty_out), W'(0));
    check("m0_data_last", data_out, mk(0, 0, 104));
    tick();
    check("m0_drained", W'(empty_out), W'(1));

    // max=1 back-pressure: held output blocks only the last thread.
    do_reset();
    ent_a = mk(1, 1, 16'hAAAA);
    ent_b = mk(1, 1, 16'hBBBB);
    empty_in = 1'b0;
    data_in  = mk(0, 1, 16'hAAAA);
    tick();
    data_in = ent_a;
    #1;
    check("bp_a1_rden", W'(rden_out), W'(1));
    tick();
    data_in = mk(0, 1, 16'hBBBB);
    #1;
    check("bp_a_held", W'(empty_out), W'(0));
    check("bp_b0_rden", W'(rden_out), W'(1));
    tick();
    data_in = ent_b;
    #1;
    check("bp_b1_stall", W'(rden_out), W'(0));
    tick();
    check("bp_b1_stall2", W'(rden_out), W'(0));
    check("bp_a_data", data_out, ent_a);
    rden_in = 1'b1;
    #1;
    check("bp_b1_go", W'(rden_out), W'(1));
    tick();
    rden_in  = 1'b0;
    empty_in = 1'b1;
    #1;
    check("bp_b_valid", W'(empty_out), W'(0));
    check("bp_b_data", data_out, ent_b);

    // Underflow is sticky and cleared only by reset.
    do_reset();
    #1;
    check("uf_clear", W'(underflow_out), W'(0));
    rden_in = 1'b1;
    tick();
    rden_in = 1'b0;
    check("uf_set", W'(underflow_out), W'(1));
    check("uf_no_state", W'(empty_out), W'(1));
    tick();
    check("uf_sticky", W'(underflow_out), W'(1));
    do_reset();
    #1;
    check("uf_reset", W'(underflow_out), W'(0));

    // Out-of-order tids: max=2, tids 0 then 2.
`ifdef KANAGAWA_LOOP_COLLECTOR_SEQ_CHECK_EN
    exp_seq = 1'b1;
`else
    exp_seq = 1'b0;
`endif
    empty_in = 1'b0;
    data_in  = mk(0, 2, 16'h5E0);
    tick();
    check("seq_in_order", W'(sequence_error_out), W'(0));
    data_in = mk(2, 2, 16'h5E2);
    tick();
    empty_in = 1'b1;
    check("seq_flag", W'(sequence_error_out), W'(exp_seq));
    check("seq_out_valid", W'(empty_out), W'(0));
    check("seq_out_data", data_out, mk(2, 2, 16'h5E2));

    // Literal max=7: partial call discarded by reset, then a full call.
    // The [15:8] field is set to 3 to show it is ignored in literal mode.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      l_empty_in = 1'b0;
      l_data_in  = mk(k, 3, 16'h7000 + k);
      tick();
    end
    l_empty_in = 1'b1;
    check("lit_partial_empty", W'(l_empty_out), W'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      l_empty_in = 1'b0;
      l_data_in  = mk(k, 3, 16'h7100 + k);
      #1;
      check($sformatf("lit_rden_t%0d", k), W'(l_rden_out), W'(1));
      tick();
      l_empty_in = 1'b1;
      check($sformatf("lit_empty_after_t%0d", k), W'(l_empty_out), W'(k == 7 ? 0 : 1));
    end
    check("lit_data", l_data_out, mk(7, 3, 16'h7107));
    l_rden_in = 1'b1;
    tick();
    l_rden_in = 1'b0;
    check("lit_drained", W'(l_empty_out), W'(1));
    check("lit_no_underflow", W'(l_underflow_out), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
